// File: rtl/mux4_arb_pkg.sv
// Shared types and helpers for the four-way round-robin arbiter that drives
// the NAND 4:1 mux selects.
package mux4_arb_pkg;

    localparam int NUM_REQ = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    typedef logic [1:0] owner_t;

    // Mux wiring: s0 carries the upper index bit, s1 the lower one.
    function automatic logic [1:0] idx_to_sel(input owner_t idx);
        return {idx[1], idx[0]};
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotating first-set-bit picker: scans req starting at index start, wrapping
// modulo 4, and reports the first requester found.
module rr_pick4
    import mux4_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  owner_t             start,
    output logic               found,
    output owner_t             idx
);

    owner_t             cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] hit;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        assign cand_idx[gi] = start + owner_t'(gi);
        assign hit[gi]      = req[cand_idx[gi]];
    end

    // Walk from the farthest candidate down so the nearest one wins.
    always_comb begin
        found = 1'b0;
        idx   = start;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (hit[i]) begin
                found = 1'b1;
                idx   = cand_idx[i];
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing the 4:1 NAND mux between requesters a..d, with a
// bounded hold per tenure. Optional owner lock enabled by MUX4_ARB_LOCK_EN.
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
`ifdef MUX4_ARB_LOCK_EN
    input  logic               lock,
`endif
    output logic [NUM_REQ-1:0] gnt,
    output logic               s0,
    output logic               s1,
    output logic               busy,
    output owner_t             owner
);

    arb_state_t         state_reg, state_next;
    owner_t             owner_reg, owner_next;
    owner_t             ptr_reg, ptr_next;
    logic [NUM_REQ-1:0] gnt_reg, gnt_next;
    logic [1:0]         sel_reg, sel_next;
    logic               busy_reg, busy_next;
    logic [CNT_W-1:0]   hold_cnt_reg, hold_cnt_next;
    logic               lock_hit_reg, lock_hit_next;
    logic               load_new;

    logic [NUM_REQ-1:0] own_mask;
    logic [NUM_REQ-1:0] pick_req;
    owner_t             pick_start;
    logic               pick_found;
    owner_t             pick_idx;
    logic               release_w;
    logic               expiry;
    logic               lock_act;

`ifdef MUX4_ARB_LOCK_EN
    assign lock_act = lock;
    logic lock_hit;
    assign lock_hit = lock_hit_reg;
`else
    assign lock_act = 1'b0;
`endif

    // In GRANT the current owner is masked out so the pick reports only rivals.
    assign own_mask   = NUM_REQ'(1) << owner_reg;
    assign pick_req   = (state_reg == ST_GRANT) ? (req & ~own_mask) : req;
    assign pick_start = (state_reg == ST_GRANT) ? owner_reg + owner_t'(1) : ptr_reg;
    assign release_w  = ~|(req & own_mask);
    assign expiry     = (hold_cnt_reg == CNT_W'(MAX_HOLD - 1));

    rr_pick4 u_pick (
        .req   (pick_req),
        .start (pick_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            owner_reg    <= '0;
            ptr_reg      <= '0;
            gnt_reg      <= '0;
            sel_reg      <= '0;
            busy_reg     <= 1'b0;
            hold_cnt_reg <= '0;
            lock_hit_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            owner_reg    <= owner_next;
            ptr_reg      <= ptr_next;
            gnt_reg      <= gnt_next;
            sel_reg      <= sel_next;
            busy_reg     <= busy_next;
            hold_cnt_reg <= hold_cnt_next;
            lock_hit_reg <= lock_hit_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        hold_cnt_next = hold_cnt_reg;
        lock_hit_next = lock_hit_reg;
        load_new      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                hold_cnt_next = '0;
                if (pick_found) begin
                    state_next = ST_GRANT;
                    load_new   = 1'b1;
                end
            end
            ST_GRANT: begin
                if (release_w) begin
                    if (pick_found) load_new = 1'b1;
                    else            state_next = ST_IDLE;
                end else if (expiry) begin
                    if (lock_act) begin
                        if (pick_found) lock_hit_next = 1'b1;
                    end else if (pick_found) begin
                        load_new = 1'b1;
                    end else begin
                        hold_cnt_next = '0;
                    end
                end else begin
                    hold_cnt_next = hold_cnt_reg + CNT_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (load_new) hold_cnt_next = '0;
        if (state_next == ST_IDLE) hold_cnt_next = '0;
    end

    always_comb begin
        owner_next = owner_reg;
        ptr_next   = ptr_reg;
        gnt_next   = gnt_reg;
        sel_next   = sel_reg;
        busy_next  = busy_reg;
        if (load_new) begin
            owner_next = pick_idx;
            ptr_next   = pick_idx + owner_t'(1);
            gnt_next   = NUM_REQ'(1) << pick_idx;
            sel_next   = idx_to_sel(pick_idx);
            busy_next  = 1'b1;
        end else if (state_next == ST_IDLE) begin
            owner_next = '0;
            gnt_next   = '0;
            sel_next   = '0;
            busy_next  = 1'b0;
        end
    end

    assign gnt   = gnt_reg;
    assign s0    = sel_reg[1];
    assign s1    = sel_reg[0];
    assign busy  = busy_reg;
    assign owner = owner_reg;

endmodule
